// File: rtl/mem_word_sequencer.sv
// rtl/mem_word_sequencer.sv - multi-byte big-endian LOAD/STORE/PUSH/POP sequencer onto a byte-wide memory
module mem_word_sequencer #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16,
   parameter int READ_LATENCY = 0,
   localparam int MAX_BYTES   = DATA_WIDTH / 8,
   localparam int NW          = $clog2(MAX_BYTES) + 1
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [1:0]            Mode,
   input  logic [NW-1:0]         NumBytes,
   input  logic [ADDR_WIDTH-1:0] AddrIn,
   input  logic [DATA_WIDTH-1:0] WDataIn,
   output logic [ADDR_WIDTH-1:0] Mem_Addr,
   output logic                  Mem_CS,
   output logic                  Mem_WR,
   output logic [7:0]            Mem_WData,
   input  logic [7:0]            Mem_RData,
   output logic [DATA_WIDTH-1:0] RDataOut,
   output logic [ADDR_WIDTH-1:0] AddrOut,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Error
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_FINISH} state_t;
   localparam logic [1:0] M_LOAD = 2'b00, M_STORE = 2'b01, M_PUSH = 2'b10, M_POP = 2'b11;

   state_t                state;
   logic [1:0]            mode_q;
   logic [NW-1:0]         count_q, idx, byte_sel;
   logic [ADDR_WIDTH-1:0] ptr_q, step_addr, end_addr;
   logic [DATA_WIDTH-1:0] wdata_q, acc, acc_next;
   logic                  write_mode, busy, last, advance;

   assign write_mode = (mode_q == M_STORE) || (mode_q == M_PUSH);
   assign busy       = (state == S_ACCESS) || (state == S_WAIT);
   assign last       = (idx == count_q - NW'(1));
   // Reads with a registered memory spend a second cycle in WAIT before the byte is usable.
   assign advance    = (state == S_WAIT) ||
                       (state == S_ACCESS && (write_mode || READ_LATENCY == 0));
   assign acc_next   = (acc << 8) | DATA_WIDTH'(Mem_RData);
   assign end_addr   = (mode_q == M_PUSH) ? ptr_q - ADDR_WIDTH'(count_q)
                                          : ptr_q + ADDR_WIDTH'(count_q);
   assign byte_sel   = (mode_q == M_PUSH) ? idx : count_q - NW'(1) - idx;

   always_comb begin
      case (mode_q)
         M_PUSH:  step_addr = ptr_q - ADDR_WIDTH'(idx);
         M_POP:   step_addr = ptr_q + ADDR_WIDTH'(idx) + ADDR_WIDTH'(1);
         default: step_addr = ptr_q + ADDR_WIDTH'(idx);
      endcase
   end

   assign Busy      = busy;
   assign Mem_CS    = ~busy;
   assign Mem_WR    = (state == S_ACCESS) && write_mode;
   assign Mem_Addr  = busy ? step_addr : '0;
   assign Mem_WData = Mem_WR ? wdata_q[{byte_sel, 3'b000} +: 8] : 8'h00;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state    <= S_IDLE;
         mode_q   <= M_LOAD;
         count_q  <= '0;
         idx      <= '0;
         ptr_q    <= '0;
         wdata_q  <= '0;
         acc      <= '0;
         RDataOut <= '0;
         AddrOut  <= '0;
         Done     <= 1'b0;
         Error    <= 1'b0;
      end else begin
         Done  <= 1'b0;
         Error <= 1'b0;
         case (state)
            S_IDLE: begin
               if (Start) begin
                  if (NumBytes == '0 || int'(NumBytes) > MAX_BYTES) begin
                     Error <= 1'b1;
                  end else begin
                     mode_q  <= Mode;
                     count_q <= NumBytes;
                     ptr_q   <= AddrIn;
                     wdata_q <= WDataIn;
                     acc     <= '0;
                     idx     <= '0;
                     state   <= S_ACCESS;
                  end
               end
            end
            S_ACCESS, S_WAIT: if (!advance) state <= S_WAIT;
            S_FINISH: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
         if (advance) begin
            if (!write_mode) acc <= acc_next;
            if (last) begin
               state   <= S_FINISH;
               Done    <= 1'b1;
               AddrOut <= end_addr;
               if (!write_mode) RDataOut <= acc_next;
            end else begin
               idx   <= idx + NW'(1);
               state <= S_ACCESS;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_word_sequencer.sv
// tb/tb_mem_word_sequencer.sv - randomized self-checking bench for mem_word_sequencer
module tb_mem_word_sequencer;
   localparam int DW = 32;
   localparam int AW = 16;
   localparam logic [1:0] LOAD = 2'b00, STORE = 2'b01, PUSH = 2'b10, POP = 2'b11;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start0 = 1'b0, start1 = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic [2:0]    nbytes = 3'd0;
   logic [AW-1:0] addr_in = '0;
   logic [DW-1:0] wdata = '0;

   logic [AW-1:0] maddr0, maddr1, ao0, ao1;
   logic          mcs0, mcs1, mwr0, mwr1, busy0, busy1, done0, done1, err0, err1;
   logic [7:0]    mwd0, mwd1, mrd0, mrd1, rd1_q;
   logic [DW-1:0] rdo0, rdo1;

   logic [7:0] mem0 [65536];
   logic [7:0] mem1 [65536];
   logic [7:0] refm0 [65536];
   logic [7:0] refm1 [65536];
   logic [DW-1:0] model_rd [2];
   logic [AW-1:0] model_ao [2];

   int n_checks = 0;
   int n_errs   = 0;

   logic          sel = 1'b0;
   logic          busy_s, done_s, err_s, mcs_s;
   logic [DW-1:0] rdo_s;
   logic [AW-1:0] ao_s;
   assign busy_s = sel ? busy1 : busy0;
   assign done_s = sel ? done1 : done0;
   assign err_s  = sel ? err1  : err0;
   assign mcs_s  = sel ? mcs1  : mcs0;
   assign rdo_s  = sel ? rdo1  : rdo0;
   assign ao_s   = sel ? ao1   : ao0;

   mem_word_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(0)) dut0 (
      .Clock(clk), .Reset(rst_n), .Start(start0), .Mode(mode), .NumBytes(nbytes),
      .AddrIn(addr_in), .WDataIn(wdata), .Mem_Addr(maddr0), .Mem_CS(mcs0), .Mem_WR(mwr0),
      .Mem_WData(mwd0), .Mem_RData(mrd0), .RDataOut(rdo0), .AddrOut(ao0), .Busy(busy0),
      .Done(done0), .Error(err0));

   mem_word_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut1 (
      .Clock(clk), .Reset(rst_n), .Start(start1), .Mode(mode), .NumBytes(nbytes),
      .AddrIn(addr_in), .WDataIn(wdata), .Mem_Addr(maddr1), .Mem_CS(mcs1), .Mem_WR(mwr1),
      .Mem_WData(mwd1), .Mem_RData(mrd1), .RDataOut(rdo1), .AddrOut(ao1), .Busy(busy1),
      .Done(done1), .Error(err1));

   always #5 clk = ~clk;

   // Byte memories: dut0 sees combinational reads, dut1 a one-cycle registered read.
   always @(posedge clk) begin
      if (!mcs0 && mwr0) mem0[maddr0] <= mwd0;
      if (!mcs1 && mwr1) mem1[maddr1] <= mwd1;
      rd1_q <= mem1[maddr1];
   end
   assign mrd0 = mem0[maddr0];
   assign mrd1 = rd1_q;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] dmem(input logic w, input logic [15:0] a);
      return w ? mem1[a] : mem0[a];
   endfunction

   function automatic logic [7:0] rmem(input logic w, input logic [15:0] a);
      return w ? refm1[a] : refm0[a];
   endfunction

   task automatic rset(input logic w, input logic [15:0] a, input logic [7:0] b);
      if (w) refm1[a] = b; else refm0[a] = b;
   endtask

   task automatic preload(input logic w, input logic [15:0] a, input logic [7:0] b);
      rset(w, a, b);
      if (w) mem1[a] = b; else mem0[a] = b;
   endtask

   task automatic mem_check(input string tag, input logic w, input logic [15:0] a);
      int bad = 0;
      for (int d = -6; d <= 6; d++) begin
         if (dmem(w, a + 16'(d)) !== rmem(w, a + 16'(d))) bad++;
      end
      check(tag, bad, 0);
   endtask

   task automatic do_op(input logic w, input logic [1:0] m, input int n,
                        input logic [15:0] a, input logic [31:0] wd, input bit inject);
      bit   legal, wr, got_done;
      int   cyc, exp_lat, bad;
      logic [31:0] acc;
      logic [15:0] ad;
      sel   = w;
      legal = (n >= 1 && n <= 4);
      wr    = (m == STORE || m == PUSH);
      if (legal) begin
         // Big-endian view: byte i counts from the most significant transferred byte.
         if (!wr) begin
            acc = 0;
            for (int i = 0; i < n; i++) begin
               ad  = (m == LOAD) ? a + 16'(i) : a + 16'(i + 1);
               acc = (acc << 8) | 32'(rmem(w, ad));
            end
            model_rd[w] = acc;
         end else begin
            for (int i = 0; i < n; i++) begin
               ad = (m == STORE) ? a + 16'(i) : a - 16'(n - 1 - i);
               rset(w, ad, wd[8*(n-1-i) +: 8]);
            end
         end
         model_ao[w] = (m == PUSH) ? a - 16'(n) : a + 16'(n);
      end
      exp_lat = 1 + n * ((wr || !w) ? 1 : 2);

      @(negedge clk);
      mode = m; nbytes = 3'(n); addr_in = a; wdata = wd;
      if (w) start1 = 1'b1; else start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
      if (!legal) begin
         check("err_pulse", err_s, 1'b1);
         check("err_cs_idle", mcs_s, 1'b1);
         @(posedge clk); #1;
         check("err_one_cycle", err_s, 1'b0);
         bad = 0;
         for (int k = 0; k < 3; k++) begin
            if (done_s || !mcs_s || busy_s) bad++;
            @(posedge clk); #1;
         end
         check("err_no_activity", bad, 0);
      end else begin
         check("busy_on", busy_s, 1'b1);
         cyc = 1; got_done = 0;
         while (cyc < 40) begin
            if (cyc == 3) begin start0 = 1'b0; start1 = 1'b0; end
            if (done_s) begin got_done = 1; break; end
            if (inject && cyc == 2) begin
               if (w) start1 = 1'b1; else start0 = 1'b1;
            end
            @(posedge clk); #1; cyc++;
         end
         start0 = 1'b0; start1 = 1'b0;
         check("done_seen", got_done, 1'b1);
         check("latency", cyc, exp_lat);
         check("busy_off", busy_s, 1'b0);
         check("rdata", rdo_s, model_rd[w]);
         check("addr_out", ao_s, model_ao[w]);
         @(posedge clk); #1;
         check("done_one_cycle", done_s, 1'b0);
      end
      check("addr_hold", ao_s, model_ao[w]);
      mem_check("mem_window", w, a);
   endtask

   initial begin
      logic [7:0] b;
      logic [1:0] m;
      logic [15:0] a;
      for (int i = 0; i < 65536; i++) begin
         b = 8'($urandom); mem0[i] = b; refm0[i] = b;
         b = 8'($urandom); mem1[i] = b; refm1[i] = b;
      end
      model_rd[0] = 0; model_rd[1] = 0; model_ao[0] = 0; model_ao[1] = 0;

      #1;
      check("rst_cs", {mcs0, mcs1}, 2'b11);
      check("rst_wr", {mwr0, mwr1}, 2'b00);
      check("rst_flags", {busy0, done0, err0, busy1, done1, err1}, 6'b0);
      check("rst_vals", {rdo0, ao0, maddr0, mwd0}, 72'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Abort a 4-byte STORE after two bytes have been written.
      @(negedge clk);
      sel = 0; mode = STORE; nbytes = 3'd4; addr_in = 16'h0008; wdata = 32'h06000A08;
      start0 = 1'b1;
      @(posedge clk); #1; start0 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0; #1;
      check("abort_cs", mcs0, 1'b1);
      check("abort_busy", busy0, 1'b0);
      check("abort_ao", ao0, 16'h0000);
      rset(0, 16'h0008, 8'h06); rset(0, 16'h0009, 8'h00);
      @(posedge clk); #1;
      mem_check("abort_mem", 0, 16'h0008);
      @(negedge clk); rst_n = 1'b1;

      do_op(0, STORE, 4, 16'h0008, 32'h06000A08, 0);
      check("store_bytes", {mem0[8], mem0[9], mem0[10], mem0[11]}, 32'h06000A08);
      preload(0, 16'h0000, 8'h06); preload(0, 16'h0001, 8'h00);
      do_op(0, LOAD, 2, 16'h0000, 0, 0);
      check("load_val", rdo0, 32'h00000600);
      preload(1, 16'h0000, 8'h06); preload(1, 16'h0001, 8'h00);
      do_op(1, LOAD, 2, 16'h0000, 0, 0);
      check("load_rl1_val", rdo1, 32'h00000600);
      do_op(0, PUSH, 2, 16'h00FF, 32'h0000AABB, 0);
      check("push_bytes", {mem0[16'h00FE], mem0[16'h00FF]}, 16'hAABB);
      do_op(0, POP, 2, 16'h00FD, 0, 0);
      check("pop_val", {rdo0, ao0}, {32'h0000AABB, 16'h00FF});
      do_op(0, LOAD, 4, 16'hFFFE, 0, 0);
      check("wrap_load_ao", ao0, 16'h0002);
      do_op(0, PUSH, 2, 16'h0000, 32'h12345678, 0);
      check("wrap_push_ao", ao0, 16'hFFFE);
      do_op(0, LOAD, 0, 16'h1234, 0, 0);
      do_op(0, STORE, 5, 16'h1234, 32'hDEADBEEF, 0);
      do_op(0, STORE, 4, 16'h0100, 32'hCAFEF00D, 1);

      for (int t = 0; t < 200; t++) begin
         m = 2'($urandom);
         a = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 7)) : 16'($urandom);
         do_op(0, m, $urandom_range(0, 5), a, $urandom, 1'($urandom));
      end
      for (int t = 0; t < 80; t++) begin
         m = $urandom_range(0, 1) ? POP : LOAD;
         a = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 7)) : 16'($urandom);
         do_op(1, m, $urandom_range(0, 5), a, $urandom, 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
